// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: a DEPTH-entry circular buffer with valid/ready on both sides,
// synchronous flush, and a saturating count of cycles in which the head was held back.
module pipe_reg_elastic #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [15:0]                stall_cycles
);

  localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW   = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("pipe_reg_elastic: DEPTH must be in 1..4");
    end
  endgenerate

  logic [WIDTH-1:0] slot [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high and
  // flush is low. in_ready/out_valid come only from the registered count, never from inputs.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_data  = out_valid ? slot[rd_ptr] : RESET_VAL;
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot[i] <= RESET_VAL;
      end
    end else begin
      if (push) begin
        slot[wr_ptr] <= in_data;
        wr_ptr       <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Survives flush on purpose so stalls across mispredicts stay visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: a DEPTH=2 and a DEPTH=3 instance share one stimulus stream and are
// checked every cycle against a shift-array FIFO model, plus directed literal checks on DEPTH=2.
module tb_pipe_reg_elastic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        ir   [2];
  logic        ov   [2];
  logic [31:0] dout [2];
  logic [1:0]  occ  [2];
  logic [15:0] stl  [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state per instance: index 0 is DEPTH=2, index 1 is DEPTH=3
  int          dep  [2] = '{2, 3};
  int          mcnt [2];
  logic [31:0] mbuf [2][4];
  logic [15:0] mstall [2];

  always #5 clk = ~clk;

  pipe_reg_elastic #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'h0)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(dout[0]),
    .occupancy(occ[0]), .stall_cycles(stl[0])
  );

  pipe_reg_elastic #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0)) dut3 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(dout[1]),
    .occupancy(occ[1]), .stall_cycles(stl[1])
  );

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[d%0d] got=%0h exp=%0h t=%0t", name, dep[k], act, exp, $time);
    end
  endtask

  // Reference: FIFO as a shift array; head is always element 0.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mcnt[k]   = 0;
        mstall[k] = 16'h0;
      end else begin
        bit acc;
        if (mcnt[k] != 0 && !out_ready && mstall[k] != 16'hFFFF) mstall[k] = mstall[k] + 16'd1;
        if (flush) begin
          mcnt[k] = 0;
        end else begin
          acc = in_valid && (mcnt[k] < dep[k]);
          if (mcnt[k] != 0 && out_ready) begin
            for (int j = 0; j < 3; j++) mbuf[k][j] = mbuf[k][j+1];
            mcnt[k] = mcnt[k] - 1;
          end
          if (acc) begin
            mbuf[k][mcnt[k]] = in_data;
            mcnt[k] = mcnt[k] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("out_valid", k, 32'(ov[k]), 32'(mcnt[k] != 0));
        check("in_ready", k, 32'(ir[k]), 32'(mcnt[k] < dep[k]));
        check("occupancy", k, 32'(occ[k]), 32'(mcnt[k]));
        check("out_data", k, dout[k], (mcnt[k] != 0) ? mbuf[k][0] : 32'h0);
        check("stall_cycles", k, 32'(stl[k]), 32'(mstall[k]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held two cycles with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h55;
    cyc(); cyc();
    check("rst_out_valid", 0, 32'(ov[0]), 32'h0);
    check("rst_in_ready", 0, 32'(ir[0]), 32'h1);
    check("rst_occ", 0, 32'(occ[0]), 32'h0);
    check("rst_data", 0, dout[0], 32'h0);
    check("rst_stall", 0, 32'(stl[0]), 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    chk_en = 1'b1;
    cyc();

    // streaming with out_ready high: 1-cycle latency, occupancy stays 1
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 32'h11; cyc();
    check("stream_d0", 0, dout[0], 32'h11);
    check("stream_occ0", 0, 32'(occ[0]), 32'h1);
    in_data = 32'h22; cyc();
    check("stream_d1", 0, dout[0], 32'h22);
    check("stream_ir1", 0, 32'(ir[0]), 32'h1);
    in_data = 32'h33; cyc();
    check("stream_d2", 0, dout[0], 32'h33);
    check("stream_occ2", 0, 32'(occ[0]), 32'h1);
    in_valid = 1'b0; cyc();
    check("stream_empty", 0, 32'(ov[0]), 32'h0);

    // back-pressure: A, B accepted, C refused, A held
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hA; cyc();
    in_data = 32'hB; cyc();
    check("bp_full_ir", 0, 32'(ir[0]), 32'h0);
    in_data = 32'hC; cyc();
    check("bp_hold_data", 0, dout[0], 32'hA);
    check("bp_occ", 0, 32'(occ[0]), 32'h2);
    check("bp_stall", 0, 32'(stl[0]), 32'h2);
    in_valid = 1'b0; out_ready = 1'b1; cyc();
    check("bp_drain_b", 0, dout[0], 32'hB);
    check("bp_ir_back", 0, 32'(ir[0]), 32'h1);
    cyc();
    check("bp_drained", 0, 32'(ov[0]), 32'h0);

    // flush while full with a simultaneous push
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h44; cyc();
    in_data = 32'h55; cyc();
    check("fl_full", 0, 32'(occ[0]), 32'h2);
    flush = 1'b1; in_data = 32'h99; out_ready = 1'b1; cyc();
    check("fl_occ", 0, 32'(occ[0]), 32'h0);
    check("fl_ov", 0, 32'(ov[0]), 32'h0);
    check("fl_data", 0, dout[0], 32'h0);
    check("fl_ir", 0, 32'(ir[0]), 32'h1);
    check("fl_stall", 0, 32'(stl[0]), 32'h3);
    flush = 1'b0; in_valid = 1'b0; cyc(); cyc();
    check("fl_no_ghost", 0, 32'(ov[0]), 32'h0);

    // randomized traffic, exercises pointer wrap on the DEPTH=3 instance
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cyc();
      check("rand_occ_le3", 1, 32'(occ[1] <= 2'd3), 32'h1);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();

    // saturation of the stall counter, then rst clears it
    rst = 1'b1; cyc(); rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; cyc();
    in_valid = 1'b0;
    repeat (70000) cyc();
    check("sat_stall", 0, 32'(stl[0]), 32'hFFFF);
    repeat (5) cyc();
    check("sat_hold", 0, 32'(stl[0]), 32'hFFFF);
    check("sat_data", 0, dout[0], 32'h77);
    rst = 1'b1; cyc();
    check("sat_rst", 0, 32'(stl[0]), 32'h0);
    rst = 1'b0; cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
